// File: rtl/gpwr_pkg.sv
// gpwr_pkg: shared types and constants for the general-purpose register file
// write-port arbiter (gp_wrport_arb) and its round-robin picker.
package gpwr_pkg;

    typedef logic [4:0] regno_t;

    // Writes to r0 are architecturally discarded.
    localparam regno_t REG_ZERO = 5'd0;

    localparam int unsigned WID_DEF = 128;

    // One regfile write port as seen by the regfile (data width fixed at WID_DEF).
    typedef struct packed {
        logic                v;
        regno_t              wa;
        logic [WID_DEF-1:0]  d;
    } wrport_t;

endpackage

// File: rtl/gp_wrport_arb_if.sv
// gp_wrport_arb_if: bundles the requester side (hold, req_*) and the two
// registered regfile write ports (wr0/wa0/i0, wr1/wa1/i1) of gp_wrport_arb.
//   slave  : arbiter view (consumes requests, drives req_rdy and write ports)
//   master : requester/regfile view
interface gp_wrport_arb_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned WID  = 128
);
    import gpwr_pkg::*;

    logic                  hold;
    logic [NREQ-1:0]       req_v;
    logic [NREQ*5-1:0]     req_wa;
    logic [NREQ*WID-1:0]   req_d;
    logic [NREQ-1:0]       req_rdy;
    logic                  wr0;
    regno_t                wa0;
    logic [WID-1:0]        i0;
    logic                  wr1;
    regno_t                wa1;
    logic [WID-1:0]        i1;

    modport slave (
        input  hold, req_v, req_wa, req_d,
        output req_rdy, wr0, wa0, i0, wr1, wa1, i1
    );

    modport master (
        output hold, req_v, req_wa, req_d,
        input  req_rdy, wr0, wa0, i0, wr1, wa1, i1
    );
endinterface

// File: rtl/gpwr_rr_pick.sv
// gpwr_rr_pick: combinational rotate-scan. Returns the index of the first set
// bit of req_i at or after ptr_i (wrapping modulo N) and a found flag.
//   req_i   : candidate vector
//   ptr_i   : scan start position
//   found_o : some bit of req_i is set
//   idx_o   : index of the selected bit (0 when none found)
module gpwr_rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic          found_o,
    output logic [PW-1:0] idx_o
);
    always_comb begin
        int unsigned k;
        found_o = 1'b0;
        idx_o   = '0;
        k       = 0;
        for (int unsigned i = 0; i < N; i++) begin
            k = (int'(ptr_i) + i) % N;
            if (!found_o && req_i[k]) begin
                found_o = 1'b1;
                idx_o   = k[PW-1:0];
            end
        end
    end
endmodule

// File: rtl/gp_wrport_arb.sv
// gp_wrport_arb: arbitrates NREQ writeback requesters onto the two write ports
// of the general-purpose register file with round-robin fairness.
//   clk, rst : clock and synchronous active-high reset
//   bus      : gp_wrport_arb_if.slave (hold, req_v/wa/d in; req_rdy, wr/wa/i out)
// Writes to r0 are acknowledged without using a port. Port 1 never carries the
// same register as port 0 in one cycle. Write ports are registered.
// Optional build macro GPWR_PERF_EN adds perf_grants/perf_conflicts/perf_stalls.
module gp_wrport_arb
    import gpwr_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned WID  = 128
) (
    input  logic           clk,
    input  logic           rst,
    gp_wrport_arb_if.slave bus
`ifdef GPWR_PERF_EN
    ,
    output logic [31:0]    perf_grants,
    output logic [31:0]    perf_conflicts,
    output logic [31:0]    perf_stalls
`endif
);
    localparam int unsigned PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTRW-1:0] rr_ptr_q, rr_ptr_d;
    logic            wr0_q, wr0_d, wr1_q, wr1_d;
    regno_t          wa0_q, wa0_d, wa1_q, wa1_d;
    logic [WID-1:0]  i0_q, i0_d, i1_q, i1_d;

    logic [NREQ-1:0] elig, zero, mask1;
    logic            found0, found1;
    logic [PTRW-1:0] idx0, idx1;
    regno_t          wa_g0;

    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            elig[k] = bus.req_v[k] && (bus.req_wa[5*k +: 5] != REG_ZERO) && !bus.hold && !rst;
            zero[k] = bus.req_v[k] && (bus.req_wa[5*k +: 5] == REG_ZERO) && !bus.hold && !rst;
        end
    end

    gpwr_rr_pick #(.N(NREQ), .PW(PTRW)) u_pick0 (
        .req_i   (elig),
        .ptr_i   (rr_ptr_q),
        .found_o (found0),
        .idx_o   (idx0)
    );

    assign wa_g0 = bus.req_wa[5*int'(idx0) +: 5];

    // Port-1 candidates: everything after g0 in scan order except same-register
    // writers, so scanning from rr_ptr again yields the next one after g0.
    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            mask1[k] = elig[k] && (k != int'(idx0)) && (bus.req_wa[5*k +: 5] != wa_g0);
        end
    end

    gpwr_rr_pick #(.N(NREQ), .PW(PTRW)) u_pick1 (
        .req_i   (mask1),
        .ptr_i   (rr_ptr_q),
        .found_o (found1),
        .idx_o   (idx1)
    );

    always_comb begin
        bus.req_rdy = zero;
        if (found0) bus.req_rdy[idx0] = 1'b1;
        if (found1) bus.req_rdy[idx1] = 1'b1;

        rr_ptr_d = rr_ptr_q;
        if (found1) begin
            rr_ptr_d = (int'(idx1) == NREQ - 1) ? '0 : idx1 + 1'b1;
        end else if (found0) begin
            rr_ptr_d = (int'(idx0) == NREQ - 1) ? '0 : idx0 + 1'b1;
        end

        wr0_d = found0;
        wa0_d = wa0_q;
        i0_d  = i0_q;
        if (found0) begin
            wa0_d = wa_g0;
            i0_d  = bus.req_d[WID*int'(idx0) +: WID];
        end

        wr1_d = found1;
        wa1_d = wa1_q;
        i1_d  = i1_q;
        if (found1) begin
            wa1_d = bus.req_wa[5*int'(idx1) +: 5];
            i1_d  = bus.req_d[WID*int'(idx1) +: WID];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            wr0_q    <= 1'b0;
            wa0_q    <= REG_ZERO;
            i0_q     <= '0;
            wr1_q    <= 1'b0;
            wa1_q    <= REG_ZERO;
            i1_q     <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wr0_q    <= wr0_d;
            wa0_q    <= wa0_d;
            i0_q     <= i0_d;
            wr1_q    <= wr1_d;
            wa1_q    <= wa1_d;
            i1_q     <= i1_d;
        end
    end

    assign bus.wr0 = wr0_q;
    assign bus.wa0 = wa0_q;
    assign bus.i0  = i0_q;
    assign bus.wr1 = wr1_q;
    assign bus.wa1 = wa1_q;
    assign bus.i1  = i1_q;

`ifdef GPWR_PERF_EN
    logic [31:0]     perf_grants_q, perf_grants_d;
    logic [31:0]     perf_conflicts_q, perf_conflicts_d;
    logic [31:0]     perf_stalls_q, perf_stalls_d;
    logic [NREQ-1:0] pend, granted;
    logic            conflict;

    // Stalls count pending non-zero writes even while hold masks eligibility.
    always_comb begin
        conflict = 1'b0;
        granted  = '0;
        if (found0) granted[idx0] = 1'b1;
        if (found1) granted[idx1] = 1'b1;
        for (int k = 0; k < NREQ; k++) begin
            pend[k] = bus.req_v[k] && (bus.req_wa[5*k +: 5] != REG_ZERO) && !rst;
            if (elig[k] && (k != int'(idx0)) && (bus.req_wa[5*k +: 5] == wa_g0)) begin
                conflict = 1'b1;
            end
        end
        perf_grants_d    = perf_grants_q + 32'(found0) + 32'(found1);
        perf_conflicts_d = perf_conflicts_q + 32'(conflict);
        perf_stalls_d    = perf_stalls_q + 32'(|(pend & ~granted));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_grants_q    <= '0;
            perf_conflicts_q <= '0;
            perf_stalls_q    <= '0;
        end else begin
            perf_grants_q    <= perf_grants_d;
            perf_conflicts_q <= perf_conflicts_d;
            perf_stalls_q    <= perf_stalls_d;
        end
    end

    assign perf_grants    = perf_grants_q;
    assign perf_conflicts = perf_conflicts_q;
    assign perf_stalls    = perf_stalls_q;
`endif

endmodule

// File: tb/tb_gp_wrport_arb.sv
// tb_gp_wrport_arb: directed self-checking bench for gp_wrport_arb (NREQ=4, WID=128).
module tb_gp_wrport_arb;
    localparam int unsigned NREQ = 4;
    localparam int unsigned WID  = 128;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    gp_wrport_arb_if #(.NREQ(NREQ), .WID(WID)) bus ();

`ifdef GPWR_PERF_EN
    logic [31:0] perf_grants, perf_conflicts, perf_stalls;
`endif

    gp_wrport_arb #(.NREQ(NREQ), .WID(WID)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef GPWR_PERF_EN
        ,
        .perf_grants    (perf_grants),
        .perf_conflicts (perf_conflicts),
        .perf_stalls    (perf_stalls)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic v, input logic [4:0] wa,
                           input logic [WID-1:0] d);
        bus.req_v[k]            = v;
        bus.req_wa[5*k +: 5]    = wa;
        bus.req_d[WID*k +: WID] = d;
    endtask

    task automatic clear_reqs();
        bus.req_v  = '0;
        bus.req_wa = '0;
        bus.req_d  = '0;
        bus.hold   = 1'b0;
    endtask

    task automatic do_reset();
        clear_reqs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.hold = 1'b0;
        for (int k = 0; k < NREQ; k++) set_req(k, 1'b1, 5'(k + 1), 128'hF0 + 128'(k));
        #1;
        total++;
        if (bus.req_rdy !== 4'b0000) begin
            $display("FAIL reset_rdy got=%b want=0000", bus.req_rdy); bad++;
        end
        step();
        step();
        total++;
        if ({bus.wr0, bus.wr1, bus.wa0, bus.wa1} !== 12'h0 || bus.i0 !== '0 || bus.i1 !== '0) begin
            $display("FAIL reset_ports got wr0=%b wr1=%b wa0=%0d wa1=%0d want all 0",
                     bus.wr0, bus.wr1, bus.wa0, bus.wa1); bad++;
        end
        rst = 1'b0;
        clear_reqs();
    endtask

    task automatic test_pair();
        do_reset();
        set_req(0, 1'b1, 5'd5, 128'hAAAA);
        set_req(1, 1'b1, 5'd7, 128'hBBBB);
        #1;
        total++;
        if (bus.req_rdy !== 4'b0011) begin
            $display("FAIL pair_rdy got=%b want=0011", bus.req_rdy); bad++;
        end
        step();
        clear_reqs();
        total++;
        if (bus.wr0 !== 1'b1 || bus.wa0 !== 5'd5 || bus.i0 !== 128'hAAAA) begin
            $display("FAIL pair_p0 got wr0=%b wa0=%0d i0=%h want 1/5/aaaa", bus.wr0, bus.wa0, bus.i0); bad++;
        end
        total++;
        if (bus.wr1 !== 1'b1 || bus.wa1 !== 5'd7 || bus.i1 !== 128'hBBBB) begin
            $display("FAIL pair_p1 got wr1=%b wa1=%0d i1=%h want 1/7/bbbb", bus.wr1, bus.wa1, bus.i1); bad++;
        end
        // rr_ptr is now 2: req2 wins port 0 ahead of req0
        set_req(0, 1'b1, 5'd1, 128'h1);
        set_req(2, 1'b1, 5'd2, 128'h2);
        step();
        clear_reqs();
        total++;
        if (bus.wa0 !== 5'd2 || bus.wa1 !== 5'd1 || bus.wr1 !== 1'b1) begin
            $display("FAIL pair_ptr2 got wa0=%0d wa1=%0d wr1=%b want 2/1/1", bus.wa0, bus.wa1, bus.wr1); bad++;
        end
    endtask

    task automatic test_rr4();
        do_reset();
        for (int k = 0; k < NREQ; k++) set_req(k, 1'b1, 5'(k + 3), 128'h100 + 128'(k));
        #1;
        total++;
        if (bus.req_rdy !== 4'b0011) begin
            $display("FAIL rr4_rdyA got=%b want=0011", bus.req_rdy); bad++;
        end
        step();
        total++;
        if (bus.wa0 !== 5'd3 || bus.wa1 !== 5'd4 || bus.i1 !== 128'h101) begin
            $display("FAIL rr4_A got wa0=%0d wa1=%0d i1=%h want 3/4/101", bus.wa0, bus.wa1, bus.i1); bad++;
        end
        total++;
        if (bus.req_rdy !== 4'b1100) begin
            $display("FAIL rr4_rdyB got=%b want=1100", bus.req_rdy); bad++;
        end
        step();
        total++;
        if (bus.wa0 !== 5'd5 || bus.wa1 !== 5'd6 || bus.i0 !== 128'h102) begin
            $display("FAIL rr4_B got wa0=%0d wa1=%0d i0=%h want 5/6/102", bus.wa0, bus.wa1, bus.i0); bad++;
        end
        total++;
        if (bus.req_rdy !== 4'b0011) begin
            $display("FAIL rr4_wrap got=%b want=0011", bus.req_rdy); bad++;
        end
        clear_reqs();
        step();
        total++;
        if (bus.wr0 !== 1'b0 || bus.wr1 !== 1'b0 || bus.wa0 !== 5'd5 || bus.wa1 !== 5'd6) begin
            $display("FAIL rr4_idle got wr0=%b wr1=%b wa0=%0d wa1=%0d want 0/0/5/6",
                     bus.wr0, bus.wr1, bus.wa0, bus.wa1); bad++;
        end
    endtask

    task automatic test_same_wa();
        do_reset();
        set_req(0, 1'b1, 5'd9, 128'hD0);
        set_req(1, 1'b1, 5'd0, 128'hD1);
        set_req(2, 1'b1, 5'd9, 128'hD2);
        #1;
        total++;
        if (bus.req_rdy !== 4'b0011) begin
            $display("FAIL samewa_rdy got=%b want=0011", bus.req_rdy); bad++;
        end
        step();
        total++;
        if (bus.wr0 !== 1'b1 || bus.wa0 !== 5'd9 || bus.i0 !== 128'hD0 || bus.wr1 !== 1'b0) begin
            $display("FAIL samewa_c1 got wr0=%b wa0=%0d i0=%h wr1=%b want 1/9/d0/0",
                     bus.wr0, bus.wa0, bus.i0, bus.wr1); bad++;
        end
        set_req(0, 1'b0, 5'd0, '0);
        set_req(1, 1'b0, 5'd0, '0);
        #1;
        total++;
        if (bus.req_rdy !== 4'b0100) begin
            $display("FAIL samewa_rdy2 got=%b want=0100", bus.req_rdy); bad++;
        end
        step();
        clear_reqs();
        total++;
        if (bus.wr0 !== 1'b1 || bus.wa0 !== 5'd9 || bus.i0 !== 128'hD2 || bus.wr1 !== 1'b0) begin
            $display("FAIL samewa_c2 got wr0=%b wa0=%0d i0=%h wr1=%b want 1/9/d2/0",
                     bus.wr0, bus.wa0, bus.i0, bus.wr1); bad++;
        end
        // A lone r0 write is acked but uses no port
        set_req(3, 1'b1, 5'd0, 128'hEE);
        #1;
        total++;
        if (bus.req_rdy !== 4'b1000) begin
            $display("FAIL zero_rdy got=%b want=1000", bus.req_rdy); bad++;
        end
        step();
        clear_reqs();
        total++;
        if (bus.wr0 !== 1'b0 || bus.wr1 !== 1'b0 || bus.i0 !== 128'hD2) begin
            $display("FAIL zero_noport got wr0=%b wr1=%b i0=%h want 0/0/d2", bus.wr0, bus.wr1, bus.i0); bad++;
        end
    endtask

    task automatic test_hold();
        do_reset();
        set_req(0, 1'b1, 5'd12, 128'hC12);
        step();
        bus.hold = 1'b1;
        for (int k = 0; k < NREQ; k++) set_req(k, 1'b1, 5'(k + 1), 128'(k));
        set_req(1, 1'b1, 5'd0, 128'h0);
        #1;
        total++;
        if (bus.req_rdy !== 4'b0000) begin
            $display("FAIL hold_rdy got=%b want=0000", bus.req_rdy); bad++;
        end
        total++;
        if (bus.wr0 !== 1'b1 || bus.wa0 !== 5'd12 || bus.i0 !== 128'hC12) begin
            $display("FAIL hold_prev got wr0=%b wa0=%0d want 1/12", bus.wr0, bus.wa0); bad++;
        end
        step();
        total++;
        if (bus.wr0 !== 1'b0 || bus.wr1 !== 1'b0 || bus.wa0 !== 5'd12) begin
            $display("FAIL hold_next got wr0=%b wr1=%b wa0=%0d want 0/0/12", bus.wr0, bus.wr1, bus.wa0); bad++;
        end
        clear_reqs();
    endtask

    task automatic test_rst_mid();
        do_reset();
        set_req(0, 1'b1, 5'd12, 128'h5A5A);
        step();
        clear_reqs();
        total++;
        if (bus.wr0 !== 1'b1 || bus.wa0 !== 5'd12) begin
            $display("FAIL rstmid_pre got wr0=%b wa0=%0d want 1/12", bus.wr0, bus.wa0); bad++;
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if (bus.wr0 !== 1'b0 || bus.wa0 !== 5'd0 || bus.i0 !== '0) begin
            $display("FAIL rstmid_clr got wr0=%b wa0=%0d i0=%h want 0/0/0", bus.wr0, bus.wa0, bus.i0); bad++;
        end
`ifdef GPWR_PERF_EN
        total++;
        if (perf_grants !== 32'd0 || perf_conflicts !== 32'd0 || perf_stalls !== 32'd0) begin
            $display("FAIL rstmid_perf got g=%0d c=%0d s=%0d want 0/0/0",
                     perf_grants, perf_conflicts, perf_stalls); bad++;
        end
`endif
        // rr_ptr back at 0: req0 takes port 0
        set_req(0, 1'b1, 5'd1, 128'h1);
        set_req(1, 1'b1, 5'd2, 128'h2);
        step();
        clear_reqs();
        total++;
        if (bus.wa0 !== 5'd1 || bus.wa1 !== 5'd2) begin
            $display("FAIL rstmid_ptr got wa0=%0d wa1=%0d want 1/2", bus.wa0, bus.wa1); bad++;
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            set_req(3, 1'b1, 5'(20 + c), 128'h300 + 128'(c));
            step();
            total++;
            if (bus.wr0 !== 1'b1 || bus.wa0 !== 5'(20 + c) || bus.i0 !== 128'h300 + 128'(c)
                || bus.wr1 !== 1'b0) begin
                $display("FAIL b2b_%0d got wr0=%b wa0=%0d i0=%h wr1=%b", c, bus.wr0, bus.wa0,
                         bus.i0, bus.wr1); bad++;
            end
        end
        clear_reqs();
    endtask

`ifdef GPWR_PERF_EN
    task automatic test_perf();
        do_reset();
        set_req(0, 1'b1, 5'd1, 128'h1);
        set_req(1, 1'b1, 5'd2, 128'h2);
        set_req(2, 1'b1, 5'd3, 128'h3);
        for (int c = 0; c < 10; c++) step();
        clear_reqs();
        step();
        total++;
        if (perf_grants !== 32'd20 || perf_stalls !== 32'd10 || perf_conflicts !== 32'd0) begin
            $display("FAIL perf_counts got g=%0d s=%0d c=%0d want 20/10/0",
                     perf_grants, perf_stalls, perf_conflicts); bad++;
        end
        set_req(0, 1'b1, 5'd8, 128'h1);
        set_req(1, 1'b1, 5'd8, 128'h2);
        step();
        clear_reqs();
        total++;
        if (perf_grants !== 32'd21 || perf_stalls !== 32'd11 || perf_conflicts !== 32'd1) begin
            $display("FAIL perf_conflict got g=%0d s=%0d c=%0d want 21/11/1",
                     perf_grants, perf_stalls, perf_conflicts); bad++;
        end
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        clear_reqs();
        test_reset();
        test_pair();
        test_rr4();
        test_same_wa();
        test_hold();
        test_rst_mid();
        test_back_to_back();
`ifdef GPWR_PERF_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gp_wrport_arb.md
Name: gp_wrport_arb

Overview:
- Arbitrates NREQ writeback requesters (ALU0, ALU1, FPU, MEM, ...) onto the two write ports (wr0/wa0/i0, wr1/wa1/i1) of the general-purpose register file.
- Grants up to two writes per cycle with round-robin fairness.
- Discards writes to r0 without consuming a port.
- Never places the same target register on both ports in one cycle.
- Outputs are registered and drive the regfile write ports directly.

Parameters:
- NREQ, 4, number of writeback requesters (2..8).
- WID, 128, register data width.
- PTRW, $clog2(NREQ), width of the round-robin pointer (derived localparam).

Ports:
- clk  in  1  core clock; all state on its rising edge.
- rst  in  1  synchronous active-high reset.
- hold  in  1  suppresses all grants this cycle (e.g. during operating-level switch).
- req_v  in  NREQ  requester k has a write pending.
- req_wa  in  NREQ*5  target register of requester k, slice [5k+4:5k].
- req_d  in  NREQ*WID  write data of requester k, slice [WID*k+WID-1:WID*k].
- req_rdy  out  NREQ  combinational accept; transfer occurs when req_v[k] and req_rdy[k] are both high.
- wr0  out  1  port-0 write enable (registered).
- wa0  out  5  port-0 register address (registered).
- i0  out  WID  port-0 data (registered).
- wr1  out  1  port-1 write enable (registered).
- wa1  out  5  port-1 register address (registered).
- i1  out  WID  port-1 data (registered).

Behaviour:
- Reset: wr0=wr1=0, wa0=wa1=0, i0=i1=0, rr_ptr=0, req_rdy=0 during rst. Requests presented during rst are not accepted.
- Eligible(k) = req_v[k] & (req_wa[k]!=0) & !hold & !rst.
- Zero(k) = req_v[k] & (req_wa[k]==0) & !hold & !rst. Then req_rdy[k]=1 and the data is discarded; no port is used and rr_ptr is not affected.
- Selection scans k = rr_ptr, rr_ptr+1, ... mod NREQ:
  - The first eligible requester is granted port 0 (g0).
  - The next eligible requester whose wa differs from g0's wa is granted port 1 (g1).
  - Eligible requesters with wa equal to g0's wa are skipped this cycle; req_rdy stays 0.
- At most two non-zero grants per cycle; req_rdy[k]=1 only for g0, g1, and Zero requesters.
- Latency is one cycle: at the next edge, wr0<=g0 valid, wa0<=req_wa[g0], i0<=req_d[g0]; likewise port 1 from g1.
  - With a single grant, it always uses port 0 and wr1<=0.
  - With no grants, wr0=wr1=0 and wa/i hold their previous values.
- rr_ptr update: (index of last granted non-zero requester + 1) mod NREQ. It is unchanged when there are no grants. Scan wraps past NREQ-1 to 0.
- hold=1: all req_rdy=0 and no new grants; next-cycle wr0=wr1=0. A write registered in the previous cycle still appears on the ports (it is already committed).
- rst asserted while a write is registered: outputs are cleared next edge and that write is lost. Requesters must re-present after reset.
- Requesters may drop req_v without a grant; the block holds no per-requester state.
- Back-to-back grants to the same requester in consecutive cycles are allowed.

Optional Feature:
- GPWR_PERF_EN defined adds outputs perf_grants[31:0], perf_conflicts[31:0] and perf_stalls[31:0]. All reset to 0 and wrap modulo 2^32.
  - perf_grants: adds the number of ports used per cycle (0, 1 or 2).
  - perf_conflicts: +1 per cycle in which at least one eligible requester is skipped due to the same-wa rule.
  - perf_stalls: +1 per cycle with any eligible requester not granted, including under hold.
- GPWR_PERF_EN undefined: these ports and counters do not exist. Arbitration behaviour is identical in both builds.

Decomposition:
- Package gpwr_pkg holds:
  - localparam REG_ZERO=5'd0.
  - typedef logic [4:0] regno_t.
  - typedef struct {logic v; regno_t wa; logic [WID-1:0] d;} wrport_t (WID passed via parameterized struct or fixed at 128).
- One natural sub-module, gpwr_rr_pick. It is a combinational rotate-scan that returns the first set bit at or after ptr, plus a found flag. It is instantiated twice: for g0, and for g1 with g0 and same-wa requesters masked off.

Test Plan:
- Reset, then req_v=4'b0011 with wa={5,7}: next cycle wr0=1/wa0=5 (req0) and wr1=1/wa1=7 (req1); rr_ptr=2.
- Four requesters valid, wa={3,4,5,6}, held 2 cycles from rr_ptr=0: cycle A grants req0/req1, cycle B grants req2/req3; rr_ptr returns to 0.
- req0 and req2 both wa=9, req1 wa=0, rr_ptr=0: req1 acked with no port use; req0 granted on port 0; req2 not ready; wr1=0; req2 granted on port 0 the following cycle.
- hold=1 with all req_v=1: all req_rdy=0; next cycle wr0=wr1=0; the previously registered write is still visible this cycle.
- rst pulsed for one cycle while wr0=1/wa0=12: next edge wr0=0, wa0=0, i0=0, rr_ptr=0. With GPWR_PERF_EN, all counters read 0.
- With GPWR_PERF_EN: 10 cycles of 3 distinct-wa requesters: perf_grants=20, perf_stalls=10, perf_conflicts=0.
